// File: rtl/wrapping_decrement_counter.sv
// -----------------------------------------------------------------------------
// wrapping_decrement_counter
//
// Down-counter over the states 0..RANGE-1. Each update can subtract a
// variable step. An update that would go below zero wraps back into range.
// RANGE does not have to be a power of two. The block also provides a
// synchronous load and a registered one-cycle "wrapped" pulse. Typical uses
// are read-side or credit-return pointers, rewinding a circular buffer, and
// countdown timers.
//
// Optional feature: define WRAPPING_DECREMENT_COUNTER_LAP_EN to add the output
// "lap". This bit toggles on every wrapping update. {lap, count} then forms a
// phase-tagged pointer that can be compared with an incrementing pointer.
//
// Parameters:
//   RANGE        number of counter states (>= 2)
//   RANGE_LOG2   width of count / load_value
//   RESET_VALUE  count after reset (< RANGE)
//   MAX_STEP     largest legal step (1..RANGE)
//   STEP_WIDTH   width of step
//
// Ports:
//   clock        in   rising-edge clock
//   resetn       in   asynchronous active-low reset
//   decrement    in   subtract step this cycle
//   step         in   amount to subtract (0..MAX_STEP)
//   load_enable  in   overwrite count with load_value (has priority)
//   load_value   in   value to load; values >= RANGE load RANGE-1
//   count        out  registered counter value
//   wrapped      out  registered pulse: the previous update wrapped below 0
//   lap          out  (feature only) toggles on every wrapping update
// -----------------------------------------------------------------------------
module wrapping_decrement_counter #(
    parameter int RANGE       = 4,
    parameter int RANGE_LOG2  = $clog2(RANGE),
    parameter int RESET_VALUE = 0,
    parameter int MAX_STEP    = 1,
    parameter int STEP_WIDTH  = $clog2(MAX_STEP + 1)
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  decrement,
    input  logic [STEP_WIDTH-1:0] step,
    input  logic                  load_enable,
    input  logic [RANGE_LOG2-1:0] load_value,
    output logic [RANGE_LOG2-1:0] count,
    output logic                  wrapped
`ifdef WRAPPING_DECREMENT_COUNTER_LAP_EN
    ,
    output logic                  lap
`endif
);

    // One extra bit of headroom, so the borrow of count - step is visible.
    localparam int EXT_WIDTH = RANGE_LOG2 + 1;

    localparam logic [EXT_WIDTH-1:0]  RANGE_EXT   = EXT_WIDTH'(RANGE);
    localparam logic [RANGE_LOG2-1:0] RANGE_LOW   = RANGE_LOG2'(RANGE);
    localparam logic [RANGE_LOG2-1:0] LAST_COUNT  = RANGE_LOG2'(RANGE - 1);
    localparam logic [RANGE_LOG2-1:0] RESET_COUNT = RANGE_LOG2'(RESET_VALUE);

    logic [RANGE_LOG2-1:0] r_count;
    logic                  r_wrapped;

    logic [EXT_WIDTH-1:0]  w_step_ext;
    logic [EXT_WIDTH-1:0]  w_diff;
    logic                  w_borrow;
    logic [RANGE_LOG2-1:0] w_dec_count;
    logic [RANGE_LOG2-1:0] w_load_count;
    logic [RANGE_LOG2-1:0] w_next_count;
    logic                  w_next_wrapped;

    // A negative difference means step > count. The MSB of the extended
    // difference is the borrow.
    assign w_step_ext = EXT_WIDTH'(step);
    assign w_diff     = {1'b0, r_count} - w_step_ext;
    assign w_borrow   = w_diff[EXT_WIDTH-1];

    // After a wrap the true result is count + RANGE - step, which lies in
    // [0, RANGE). The addition can therefore be done in RANGE_LOG2 bits.
    // For a power-of-two RANGE, RANGE_LOW is 0, so this collapses to plain
    // modular subtraction. Both kinds of RANGE use the same expression.
    assign w_dec_count = w_diff[RANGE_LOG2-1:0] + (w_borrow ? RANGE_LOW : '0);

    // An out-of-range load value saturates to the last legal state.
    assign w_load_count = ({1'b0, load_value} >= RANGE_EXT) ? LAST_COUNT : load_value;

    always_comb begin
        // NOTE: every output of this block gets a default first. Any path that
        // leaves a signal unassigned would otherwise infer a latch.
        w_next_count   = r_count;
        w_next_wrapped = 1'b0;
        if (load_enable) begin
            w_next_count = w_load_count;
        end else if (decrement) begin
            w_next_count   = w_dec_count;
            w_next_wrapped = w_borrow;
        end
    end

    // NOTE: state flops use non-blocking assignments. All flops then sample
    // pre-edge values, whatever order the blocks are evaluated in.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_count   <= RESET_COUNT;
            r_wrapped <= 1'b0;
        end else begin
            r_count   <= w_next_count;
            r_wrapped <= w_next_wrapped;
        end
    end

    assign count   = r_count;
    assign wrapped = r_wrapped;

`ifdef WRAPPING_DECREMENT_COUNTER_LAP_EN
    logic r_lap;

    // A load does not change lap. Only a wrapping decrement flips the phase.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_lap <= 1'b0;
        end else if (!load_enable && decrement && w_borrow) begin
            r_lap <= ~r_lap;
        end
    end

    assign lap = r_lap;
`endif

`ifndef SYNTHESIS
    a_step_legal : assert property (
        @(posedge clock) disable iff (!resetn)
        decrement |-> (EXT_WIDTH'(step) <= EXT_WIDTH'(MAX_STEP))
    ) else $error("wrapping_decrement_counter: step %0d exceeds MAX_STEP %0d", step, MAX_STEP);
`endif

endmodule

// File: tb/tb_wrapping_decrement_counter.sv
module tb_wrapping_decrement_counter;

    typedef struct {
        int cnt;
        bit wr;
        bit lp;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic clock;
    logic resetn;

    // RANGE=5, MAX_STEP=1 (non-power-of-2, single step)
    logic       d5, l5;
    logic [0:0] s5;
    logic [2:0] lv5, c5;
    logic       w5;
    // RANGE=8, MAX_STEP=3 (power-of-2, multi-step)
    logic       d8, l8;
    logic [1:0] s8;
    logic [2:0] lv8, c8;
    logic       w8;
    // RANGE=6, MAX_STEP=6 (non-power-of-2, step may equal RANGE)
    logic       d6, l6;
    logic [2:0] s6, lv6, c6;
    logic       w6;
    // RANGE=4, MAX_STEP=1 (power-of-2, lap feature when enabled)
    logic       d4, l4;
    logic [0:0] s4;
    logic [1:0] lv4, c4;
    logic       w4;
    logic       lp4;

    wrapping_decrement_counter #(.RANGE(5), .RESET_VALUE(0), .MAX_STEP(1)) u5 (
        .clock(clock), .resetn(resetn), .decrement(d5), .step(s5),
        .load_enable(l5), .load_value(lv5), .count(c5), .wrapped(w5)
`ifdef WRAPPING_DECREMENT_COUNTER_LAP_EN
        , .lap()
`endif
    );

    wrapping_decrement_counter #(.RANGE(8), .RESET_VALUE(0), .MAX_STEP(3)) u8 (
        .clock(clock), .resetn(resetn), .decrement(d8), .step(s8),
        .load_enable(l8), .load_value(lv8), .count(c8), .wrapped(w8)
`ifdef WRAPPING_DECREMENT_COUNTER_LAP_EN
        , .lap()
`endif
    );

    wrapping_decrement_counter #(.RANGE(6), .RESET_VALUE(0), .MAX_STEP(6)) u6 (
        .clock(clock), .resetn(resetn), .decrement(d6), .step(s6),
        .load_enable(l6), .load_value(lv6), .count(c6), .wrapped(w6)
`ifdef WRAPPING_DECREMENT_COUNTER_LAP_EN
        , .lap()
`endif
    );

    wrapping_decrement_counter #(.RANGE(4), .RESET_VALUE(0), .MAX_STEP(1)) u4 (
        .clock(clock), .resetn(resetn), .decrement(d4), .step(s4),
        .load_enable(l4), .load_value(lv4), .count(c4), .wrapped(w4)
`ifdef WRAPPING_DECREMENT_COUNTER_LAP_EN
        , .lap(lp4)
`endif
    );

`ifndef WRAPPING_DECREMENT_COUNTER_LAP_EN
    assign lp4 = 1'b0;
`endif

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset();
        resetn = 1'b0;
        d5 = 0; s5 = '0; l5 = 0; lv5 = '0;
        d8 = 0; s8 = '0; l8 = 0; lv8 = '0;
        d6 = 0; s6 = '0; l6 = 0; lv6 = '0;
        d4 = 0; s4 = '0; l4 = 0; lv4 = '0;
        #3;  // before any clock edge: reset must already be in effect
        n_cmp++; if (c5 !== 3'd0 || w5 !== 1'b0) begin n_bad++; $display("FAIL reset_u5: got count=%0d wrapped=%0b, expected 0/0", c5, w5); end
        n_cmp++; if (c8 !== 3'd0 || w8 !== 1'b0) begin n_bad++; $display("FAIL reset_u8: got count=%0d wrapped=%0b, expected 0/0", c8, w8); end
        n_cmp++; if (c6 !== 3'd0 || w6 !== 1'b0) begin n_bad++; $display("FAIL reset_u6: got count=%0d wrapped=%0b, expected 0/0", c6, w6); end
        n_cmp++; if (c4 !== 2'd0 || w4 !== 1'b0 || lp4 !== 1'b0) begin n_bad++; $display("FAIL reset_u4: got count=%0d wrapped=%0b lap=%0b, expected 0/0/0", c4, w4, lp4); end
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock); #1;
        n_cmp++; if (c5 !== 3'd0 || w5 !== 1'b0) begin n_bad++; $display("FAIL reset_idle_u5: got count=%0d wrapped=%0b, expected 0/0", c5, w5); end
    endtask

    // RANGE=4: nine single steps from 0, then a load and two more steps.
    task automatic test_pow2_lap();
        int cnt_tab[12] = '{3, 2, 1, 0, 3, 2, 1, 0, 3, 1, 0, 3};
        bit wr_tab[12]  = '{1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1};
        bit lp_tab[12]  = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 0};
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            d4 = 1'b1; s4 = 1'b1;
            l4 = (i == 9); lv4 = 2'd1;
            q.push_back('{cnt: cnt_tab[i], wr: wr_tab[i], lp: lp_tab[i]});
            @(posedge clock); #1;
            e = q.pop_front();
            n_cmp++; if (c4 !== 2'(e.cnt) || w4 !== e.wr) begin n_bad++; $display("FAIL pow2_step%0d: got count=%0d wrapped=%0b, expected %0d/%0b", i, c4, w4, e.cnt, e.wr); end
`ifdef WRAPPING_DECREMENT_COUNTER_LAP_EN
            n_cmp++; if (lp4 !== e.lp) begin n_bad++; $display("FAIL lap_step%0d: got lap=%0b, expected %0b", i, lp4, e.lp); end
`endif
        end
        @(negedge clock);
        d4 = 1'b0; l4 = 1'b0;
    endtask

    // RANGE=5 step 1 for six cycles: 4,3,2,1,0,4
    task automatic test_single_step_r5();
        int cnt_tab[6] = '{4, 3, 2, 1, 0, 4};
        bit wr_tab[6]  = '{1, 0, 0, 0, 0, 1};
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            d5 = 1'b1; s5 = 1'b1; l5 = 1'b0;
            q.push_back('{cnt: cnt_tab[i], wr: wr_tab[i], lp: 1'b0});
            @(posedge clock); #1;
            e = q.pop_front();
            n_cmp++; if (c5 !== 3'(e.cnt) || w5 !== e.wr) begin n_bad++; $display("FAIL r5_step%0d: got count=%0d wrapped=%0b, expected %0d/%0b", i, c5, w5, e.cnt, e.wr); end
        end
        @(negedge clock);
        d5 = 1'b0;
        q.push_back('{cnt: 4, wr: 1'b0, lp: 1'b0});
        @(posedge clock); #1;
        e = q.pop_front();
        n_cmp++; if (c5 !== 3'(e.cnt) || w5 !== e.wr) begin n_bad++; $display("FAIL r5_idle: got count=%0d wrapped=%0b, expected %0d/%0b", c5, w5, e.cnt, e.wr); end
    endtask

    // RANGE=8: load 2, step 3 (wrap to 7), step 3 (4), step 0 (4), idle (4)
    task automatic test_multi_step_r8();
        bit       ld_tab[5] = '{1, 0, 0, 0, 0};
        bit       dc_tab[5] = '{0, 1, 1, 1, 0};
        int       st_tab[5] = '{0, 3, 3, 0, 0};
        int       cnt_tab[5] = '{2, 7, 4, 4, 4};
        bit       wr_tab[5]  = '{0, 1, 0, 0, 0};
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            l8 = ld_tab[i]; lv8 = 3'd2; d8 = dc_tab[i]; s8 = 2'(st_tab[i]);
            q.push_back('{cnt: cnt_tab[i], wr: wr_tab[i], lp: 1'b0});
            @(posedge clock); #1;
            e = q.pop_front();
            n_cmp++; if (c8 !== 3'(e.cnt) || w8 !== e.wr) begin n_bad++; $display("FAIL r8_step%0d: got count=%0d wrapped=%0b, expected %0d/%0b", i, c8, w8, e.cnt, e.wr); end
        end
        @(negedge clock);
        l8 = 1'b0; d8 = 1'b0;
    endtask

    // RANGE=6: step=RANGE keeps count and wraps; back-to-back wraps.
    task automatic test_back_to_back_r6();
        bit ld_tab[5]  = '{1, 0, 0, 0, 0};
        int st_tab[5]  = '{0, 6, 4, 5, 1};
        int cnt_tab[5] = '{3, 3, 5, 0, 5};
        bit wr_tab[5]  = '{0, 1, 1, 0, 1};
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            l6 = ld_tab[i]; lv6 = 3'd3; d6 = 1'b1; s6 = 3'(st_tab[i]);
            q.push_back('{cnt: cnt_tab[i], wr: wr_tab[i], lp: 1'b0});
            @(posedge clock); #1;
            e = q.pop_front();
            n_cmp++; if (c6 !== 3'(e.cnt) || w6 !== e.wr) begin n_bad++; $display("FAIL r6_step%0d: got count=%0d wrapped=%0b, expected %0d/%0b", i, c6, w6, e.cnt, e.wr); end
        end
        @(negedge clock);
        l6 = 1'b0; d6 = 1'b0;
    endtask

    // RANGE=5: load beats decrement; an illegal load value saturates to 4.
    task automatic test_load_priority_r5();
        int lv_tab[3]  = '{2, 7, 5};
        int cnt_tab[3] = '{2, 4, 4};
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            l5 = 1'b1; lv5 = 3'(lv_tab[i]); d5 = 1'b1; s5 = 1'b1;
            q.push_back('{cnt: cnt_tab[i], wr: 1'b0, lp: 1'b0});
            @(posedge clock); #1;
            e = q.pop_front();
            n_cmp++; if (c5 !== 3'(e.cnt) || w5 !== e.wr) begin n_bad++; $display("FAIL r5_load%0d: got count=%0d wrapped=%0b, expected %0d/%0b", i, c5, w5, e.cnt, e.wr); end
        end
        @(negedge clock);
        l5 = 1'b0; d5 = 1'b0;
    endtask

    // Random legal traffic on RANGE=8 and RANGE=6 against a reference model.
    task automatic test_random();
        int m8 = 0, m6 = 0;
        bit x8, x6;
        for (int i = 0; i < 60; i++) begin
            int ld8 = (i == 0 || $urandom_range(0, 7) == 0) ? 1 : 0;
            int ld6 = (i == 0 || $urandom_range(0, 7) == 0) ? 1 : 0;
            int dc8 = $urandom_range(0, 3) != 0 ? 1 : 0;
            int dc6 = $urandom_range(0, 3) != 0 ? 1 : 0;
            int st8 = $urandom_range(0, 3);
            int st6 = $urandom_range(0, 6);
            int v8  = $urandom_range(0, 7);
            int v6  = $urandom_range(0, 7);
            @(negedge clock);
            l8 = 1'(ld8); d8 = 1'(dc8); s8 = 2'(st8); lv8 = 3'(v8);
            l6 = 1'(ld6); d6 = 1'(dc6); s6 = 3'(st6); lv6 = 3'(v6);
            x8 = 1'b0;
            if (ld8 != 0) m8 = (v8 >= 8) ? 7 : v8;
            else if (dc8 != 0) begin
                if (st8 > m8) begin m8 = m8 + 8 - st8; x8 = 1'b1; end
                else m8 = m8 - st8;
            end
            x6 = 1'b0;
            if (ld6 != 0) m6 = (v6 >= 6) ? 5 : v6;
            else if (dc6 != 0) begin
                if (st6 > m6) begin m6 = m6 + 6 - st6; x6 = 1'b1; end
                else m6 = m6 - st6;
            end
            q.push_back('{cnt: m8, wr: x8, lp: 1'b0});
            q.push_back('{cnt: m6, wr: x6, lp: 1'b0});
            @(posedge clock); #1;
            e = q.pop_front();
            n_cmp++; if (c8 !== 3'(e.cnt) || w8 !== e.wr) begin n_bad++; $display("FAIL rand_r8_%0d: got count=%0d wrapped=%0b, expected %0d/%0b", i, c8, w8, e.cnt, e.wr); end
            e = q.pop_front();
            n_cmp++; if (c6 !== 3'(e.cnt) || w6 !== e.wr) begin n_bad++; $display("FAIL rand_r6_%0d: got count=%0d wrapped=%0b, expected %0d/%0b", i, c6, w6, e.cnt, e.wr); end
        end
        @(negedge clock);
        l8 = 0; d8 = 0; l6 = 0; d6 = 0;
    endtask

    // Mid-cycle async reset while count=3, pending update discarded, then
    // the first decrement after release starts from 0.
    task automatic test_async_reset();
        @(negedge clock);
        l5 = 1'b1; lv5 = 3'd3; d5 = 1'b0;
        @(posedge clock); #1;
        n_cmp++; if (c5 !== 3'd3) begin n_bad++; $display("FAIL areset_preload: got count=%0d, expected 3", c5); end
        l5 = 1'b0;
        #1 resetn = 1'b0;
        #1;
        n_cmp++; if (c5 !== 3'd0 || w5 !== 1'b0) begin n_bad++; $display("FAIL areset_immediate: got count=%0d wrapped=%0b, expected 0/0", c5, w5); end
        @(negedge clock);
        d5 = 1'b1; s5 = 1'b1;
        @(posedge clock); #1;
        n_cmp++; if (c5 !== 3'd0 || w5 !== 1'b0) begin n_bad++; $display("FAIL areset_held: got count=%0d wrapped=%0b, expected 0/0", c5, w5); end
        @(negedge clock);
        resetn = 1'b1;
        q.push_back('{cnt: 4, wr: 1'b1, lp: 1'b0});
        @(posedge clock); #1;
        e = q.pop_front();
        n_cmp++; if (c5 !== 3'(e.cnt) || w5 !== e.wr) begin n_bad++; $display("FAIL areset_first_dec: got count=%0d wrapped=%0b, expected %0d/%0b", c5, w5, e.cnt, e.wr); end
        @(negedge clock);
        d5 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_pow2_lap();
        test_single_step_r5();
        test_multi_step_r8();
        test_back_to_back_r6();
        test_load_priority_r5();
        test_random();
        test_async_reset();
        if (q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
